// File: rtl/dl_request_sequencer_if.sv
// Bundle between the four core load ports, the data memory and the request sequencer.
// The master side (cores + memory) drives requests and row data; the slave side is the sequencer.
interface dl_request_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic [3:0]        MR;
    logic [ADDR_W-1:0] MADDR1;
    logic [ADDR_W-1:0] MADDR2;
    logic [ADDR_W-1:0] MADDR3;
    logic [ADDR_W-1:0] MADDR4;
    logic [63:0]       mem_data;
    logic              MEMREAD;
    logic [ADDR_W-1:0] MEMADDR;
    logic [15:0]       DOUT1;
    logic [15:0]       DOUT2;
    logic [15:0]       DOUT3;
    logic [15:0]       DOUT4;
    logic [3:0]        DVALID;
    logic              busy;

    modport master (
        output MR, MADDR1, MADDR2, MADDR3, MADDR4, mem_data,
        input  MEMREAD, MEMADDR, DOUT1, DOUT2, DOUT3, DOUT4, DVALID, busy
    );

    modport slave (
        input  MR, MADDR1, MADDR2, MADDR3, MADDR4, mem_data,
        output MEMREAD, MEMADDR, DOUT1, DOUT2, DOUT3, DOUT4, DVALID, busy
    );
endinterface

// File: rtl/dl_request_sequencer.sv
// Latches up to four core read requests, issues one memory read per distinct row
// (lowest-index pending core first) and releases all requesters together.
module dl_request_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    dl_request_sequencer_if.slave  bus
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        pend_q, pend_d;
    logic [3:0]        reqmask_q, reqmask_d;
    logic [ADDR_W-1:0] addr_q [4];
    logic [ADDR_W-1:0] addr_d [4];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              memread_q, memread_d;
    logic [ADDR_W-1:0] memaddr_q, memaddr_d;
    logic [15:0]       dout_q [4];
    logic [15:0]       dout_d [4];
    logic [3:0]        dvalid_q, dvalid_d;
    logic              busy_q, busy_d;

    logic [ADDR_W-1:0] maddr_in [4];
    logic [3:0]        pend_left;

    assign maddr_in[0] = bus.MADDR1;
    assign maddr_in[1] = bus.MADDR2;
    assign maddr_in[2] = bus.MADDR3;
    assign maddr_in[3] = bus.MADDR4;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) idx = i[1:0];
        end
        return idx;
    endfunction

    function automatic logic [ADDR_W-1:0] row_of(input logic [ADDR_W-1:0] a);
        return {2'b00, a[ADDR_W-1:2]};
    endfunction

    // Word 0 of a row sits in the most significant lane.
    function automatic logic [15:0] word_sel(input logic [63:0] d, input logic [1:0] w);
        logic [15:0] r;
        case (w)
            2'd0:    r = d[63:48];
            2'd1:    r = d[47:32];
            2'd2:    r = d[31:16];
            default: r = d[15:0];
        endcase
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        reqmask_d = reqmask_q;
        cnt_d     = cnt_q;
        memread_d = 1'b0;
        memaddr_d = memaddr_q;
        dvalid_d  = 4'b0000;
        busy_d    = busy_q;
        pend_left = pend_q;
        for (int j = 0; j < 4; j++) begin
            addr_d[j] = addr_q[j];
            dout_d[j] = dout_q[j];
        end

        // Outputs are registered, so the strobe for a row is raised on the edge entering ISSUE.
        case (state_q)
            IDLE: begin
                if (bus.MR != 4'b0000) begin
                    pend_d    = bus.MR;
                    reqmask_d = bus.MR;
                    for (int j = 0; j < 4; j++) addr_d[j] = maddr_in[j];
                    memread_d = 1'b1;
                    memaddr_d = row_of(maddr_in[lowest(bus.MR)]);
                    busy_d    = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    for (int j = 0; j < 4; j++) begin
                        if (pend_q[j] && (row_of(addr_q[j]) == memaddr_q)) begin
                            dout_d[j]    = word_sel(bus.mem_data, addr_q[j][1:0]);
                            pend_left[j] = 1'b0;
                        end
                    end
                    pend_d = pend_left;
                    if (pend_left != 4'b0000) begin
                        memread_d = 1'b1;
                        memaddr_d = row_of(addr_q[lowest(pend_left)]);
                        state_d   = ISSUE;
                    end else begin
                        dvalid_d = reqmask_q;
                        state_d  = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            reqmask_q <= '0;
            cnt_q     <= '0;
            memread_q <= 1'b0;
            memaddr_q <= '0;
            dvalid_q  <= '0;
            busy_q    <= 1'b0;
            for (int j = 0; j < 4; j++) begin
                addr_q[j] <= '0;
                dout_q[j] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            reqmask_q <= reqmask_d;
            cnt_q     <= cnt_d;
            memread_q <= memread_d;
            memaddr_q <= memaddr_d;
            dvalid_q  <= dvalid_d;
            busy_q    <= busy_d;
            for (int j = 0; j < 4; j++) begin
                addr_q[j] <= addr_d[j];
                dout_q[j] <= dout_d[j];
            end
        end
    end

    assign bus.MEMREAD = memread_q;
    assign bus.MEMADDR = memaddr_q;
    assign bus.DOUT1   = dout_q[0];
    assign bus.DOUT2   = dout_q[1];
    assign bus.DOUT3   = dout_q[2];
    assign bus.DOUT4   = dout_q[3];
    assign bus.DVALID  = dvalid_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_dl_request_sequencer.sv
// Directed bench for dl_request_sequencer: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each fed by a behavioural memory that returns a row MEM_LAT cycles after its strobe.
module tb_dl_request_sequencer;

    typedef struct packed {
        logic [3:0]       mr;
        logic [3:0][15:0] a;
        logic [2:0]       nrows;
        logic [3:0][15:0] rows;
        logic [3:0][15:0] dout;
        logic             perturb;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   sel;

    dl_request_sequencer_if #(.ADDR_W(16)) if1 ();
    dl_request_sequencer_if #(.ADDR_W(16)) if3 ();

    dl_request_sequencer #(.ADDR_W(16), .MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    dl_request_sequencer #(.ADDR_W(16), .MEM_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] row_data(input logic [15:0] r);
        if (r == 16'h0004) return 64'hAAAA_BBBB_CCCC_DDDD;
        return {4'hA, r[11:0], 4'hB, r[11:0], 4'hC, r[11:0], 4'hD, r[11:0]};
    endfunction

    // Memory models: data valid exactly MEM_LAT cycles after the strobe cycle, zero otherwise.
    logic        m1_v;
    logic [15:0] m1_r;
    logic [2:0]  m3_v;
    logic [15:0] m3_r [3];

    always @(posedge clk) begin
        m1_v    <= if1.MEMREAD;
        m1_r    <= if1.MEMADDR;
        m3_v    <= {m3_v[1:0], if3.MEMREAD};
        m3_r[0] <= if3.MEMADDR;
        m3_r[1] <= m3_r[0];
        m3_r[2] <= m3_r[1];
    end

    always_comb begin
        if1.mem_data = m1_v ? row_data(m1_r) : 64'h0;
        if3.mem_data = m3_v[2] ? row_data(m3_r[2]) : 64'h0;
    end

    logic        obs_memread;
    logic [15:0] obs_memaddr;
    logic [15:0] obs_dout [4];
    logic [3:0]  obs_dvalid;
    logic        obs_busy;

    always_comb begin
        if (sel == 0) begin
            obs_memread = if1.MEMREAD;
            obs_memaddr = if1.MEMADDR;
            obs_dout[0] = if1.DOUT1;
            obs_dout[1] = if1.DOUT2;
            obs_dout[2] = if1.DOUT3;
            obs_dout[3] = if1.DOUT4;
            obs_dvalid  = if1.DVALID;
            obs_busy    = if1.busy;
        end else begin
            obs_memread = if3.MEMREAD;
            obs_memaddr = if3.MEMADDR;
            obs_dout[0] = if3.DOUT1;
            obs_dout[1] = if3.DOUT2;
            obs_dout[2] = if3.DOUT3;
            obs_dout[3] = if3.DOUT4;
            obs_dvalid  = if3.DVALID;
            obs_busy    = if3.busy;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic [3:0] mr, input logic [3:0][15:0] a);
        if (s == 0) begin
            if1.MR = mr; if1.MADDR1 = a[0]; if1.MADDR2 = a[1]; if1.MADDR3 = a[2]; if1.MADDR4 = a[3];
        end else begin
            if3.MR = mr; if3.MADDR1 = a[0]; if3.MADDR2 = a[1]; if3.MADDR3 = a[2]; if3.MADDR4 = a[3];
        end
    endtask

    function automatic vec_t mk(input logic [3:0] mr,
                                input logic [15:0] a1, input logic [15:0] a2,
                                input logic [15:0] a3, input logic [15:0] a4,
                                input int nr,
                                input logic [15:0] r1, input logic [15:0] r2,
                                input logic [15:0] r3, input logic [15:0] r4,
                                input logic [15:0] d1, input logic [15:0] d2,
                                input logic [15:0] d3, input logic [15:0] d4,
                                input logic pt);
        vec_t v;
        v.mr = mr;
        v.a = {a4, a3, a2, a1};
        v.nrows = nr[2:0];
        v.rows = {r4, r3, r2, r1};
        v.dout = {d4, d3, d2, d1};
        v.perturb = pt;
        return v;
    endfunction

    // Inputs are set in IDLE; the next rising edge is the sampling edge (cycle 0).
    task automatic run_vec(input int s, input vec_t v, input int lat, input string tag);
        int               cyc;
        int               nr;
        bit               done;
        logic [15:0]      seen [4];
        logic [3:0][15:0] junk;
        sel = s;
        drive(s, v.mr, v.a);
        @(posedge clk);
        #1;
        if (v.perturb) begin
            junk = {4{16'h3FFC}};
            drive(s, 4'hF, junk);
        end
        cyc = 1;
        nr = 0;
        done = 0;
        for (int k = 0; k < 4; k++) seen[k] = 16'h0;
        chk({tag, "_busy"}, obs_busy, 1'b1);
        while (!done && cyc <= 40) begin
            if (obs_memread) begin
                if (nr < 4) seen[nr] = obs_memaddr;
                nr++;
            end
            if (obs_dvalid != 4'b0000) begin
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        chk({tag, "_dvalid_seen"}, done, 1'b1);
        chk({tag, "_latency"}, cyc, int'(v.nrows) * (1 + lat) + 1);
        chk({tag, "_dvalid"}, obs_dvalid, v.mr);
        chk({tag, "_nreads"}, nr, int'(v.nrows));
        for (int k = 0; k < 4; k++) begin
            if (k < int'(v.nrows)) chk({tag, "_row"}, seen[k], v.rows[k]);
        end
        for (int k = 0; k < 4; k++) chk({tag, "_dout"}, obs_dout[k], v.dout[k]);
        @(posedge clk);
        #1;
        junk = v.a;
        drive(s, 4'h0, junk);
        chk({tag, "_pulse_end"}, obs_dvalid, 4'h0);
        chk({tag, "_idle"}, obs_busy, 1'b0);
    endtask

    vec_t vecs [7];
    vec_t v3;

    initial begin
        logic [3:0][15:0] za;
        logic [3:0]       acc;
        errors = 0;
        checks = 0;
        sel = 0;
        za = '0;
        reset = 1'b1;
        drive(0, 4'h0, za);
        drive(1, 4'h0, za);

        vecs[0] = mk(4'b1111, 16'h0010, 16'h0011, 16'h0012, 16'h0013, 1,
                     16'h0004, 16'h0, 16'h0, 16'h0,
                     16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 1'b0);
        vecs[1] = mk(4'b1111, 16'h0000, 16'h0004, 16'h0008, 16'h000C, 4,
                     16'h0000, 16'h0001, 16'h0002, 16'h0003,
                     16'hA000, 16'hA001, 16'hA002, 16'hA003, 1'b0);
        vecs[2] = mk(4'b1010, 16'h0000, 16'h0021, 16'h0000, 16'h0101, 2,
                     16'h0008, 16'h0040, 16'h0, 16'h0,
                     16'hA000, 16'hB008, 16'hA002, 16'hB040, 1'b0);
        vecs[3] = mk(4'b0110, 16'h0000, 16'h0013, 16'h0013, 16'h0000, 1,
                     16'h0004, 16'h0, 16'h0, 16'h0,
                     16'hA000, 16'hDDDD, 16'hDDDD, 16'hB040, 1'b0);
        vecs[4] = mk(4'b0001, 16'hC00E, 16'h0000, 16'h0000, 16'h0000, 1,
                     16'h3003, 16'h0, 16'h0, 16'h0,
                     16'hC003, 16'hDDDD, 16'hDDDD, 16'hB040, 1'b0);
        vecs[5] = mk(4'b1101, 16'h0025, 16'h0000, 16'h0016, 16'h0027, 2,
                     16'h0009, 16'h0005, 16'h0, 16'h0,
                     16'hB009, 16'hDDDD, 16'hC005, 16'hD009, 1'b0);
        vecs[6] = mk(4'b0001, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 1,
                     16'h0004, 16'h0, 16'h0, 16'h0,
                     16'hAAAA, 16'hDDDD, 16'hC005, 16'hD009, 1'b1);
        v3 = mk(4'b1111, 16'h0014, 16'h0025, 16'h0016, 16'h0027, 2,
                16'h0005, 16'h0009, 16'h0, 16'h0,
                16'hA005, 16'hB009, 16'hC005, 16'hD009, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_memread", obs_memread, 1'b0);
            chk("rst_memaddr", obs_memaddr, 16'h0);
            chk("rst_dvalid", obs_dvalid, 4'h0);
            chk("rst_busy", obs_busy, 1'b0);
            for (int k = 0; k < 4; k++) chk("rst_dout", obs_dout[k], 16'h0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            run_vec(0, vecs[i], 1, $sformatf("vec%0d", i));
        end

        // Reset while a read is outstanding: abort cleanly with no completion pulse.
        sel = 0;
        za = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
        drive(0, 4'hF, za);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("abort_in_wait", obs_busy, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_memread", obs_memread, 1'b0);
        chk("abort_dvalid", obs_dvalid, 4'h0);
        chk("abort_busy", obs_busy, 1'b0);
        for (int k = 0; k < 4; k++) chk("abort_dout", obs_dout[k], 16'h0);
        reset = 1'b0;
        drive(0, 4'h0, za);
        acc = 4'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            acc = acc | obs_dvalid;
        end
        chk("abort_no_pulse", acc, 4'h0);
        chk("abort_stays_idle", obs_busy, 1'b0);

        run_vec(1, v3, 3, "lat3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
